// File: rtl/breg_pkg.sv
// Shared definitions for the banked register file (breg) and its write-back queue.
//   BREG_W          : data/mask width of a breg register
//   BREG_ALIAS_BASE : low-half registers 0..7 are also visible at wa+8
//   wb_req_t        : one write-back request {y, wa, wval, mask}
//   breg_hits()     : does a write to wa affect a read of qa (alias rule)
package breg_pkg;

    localparam int BREG_W = 8;
    localparam logic [3:0] BREG_ALIAS_BASE = 4'h8;

    typedef struct packed {
        logic              y;
        logic [3:0]        wa;
        logic [BREG_W-1:0] wval;
        logic [BREG_W-1:0] mask;
    } wb_req_t;

    // A write hits qa directly, or through the upward alias of the low half.
    // High-half writes never alias downward.
    function automatic logic breg_hits(input logic [3:0] wa, input logic [3:0] qa);
        logic hit;
        hit = (wa == qa);
        if (wa < BREG_ALIAS_BASE) begin
            hit = hit || ((wa + BREG_ALIAS_BASE) == qa);
        end else begin
            hit = hit;
        end
        return hit;
    endfunction

endpackage

// File: rtl/sfifo.sv
// Generic synchronous FIFO of wb_req_t.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   head       : entry at the read pointer, combinational from storage
//   count      : occupancy 0..DEPTH
//   entries    : raw storage array, slot i
//   valid      : slot i currently holds a queued entry
module sfifo
    import breg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  wb_req_t                      din,
    output wb_req_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output wb_req_t [DEPTH-1:0]          entries,
    output logic [DEPTH-1:0]             valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_req_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_wr_ptr;
    logic [CW-1:0]       r_count;
    logic                w_do_push;
    logic                w_do_pop;
    logic [PW-1:0]       w_off;

    assign w_do_push = push && (r_count != CW'(DEPTH));
    assign w_do_pop  = pop  && (r_count != CW'(0));

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= PW'(0);
            r_wr_ptr <= PW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; a push during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        valid = '0;
        w_off = PW'(0);
        for (int i = 0; i < DEPTH; i++) begin
            w_off    = PW'(i) - r_rd_ptr;
            valid[i] = (CW'(w_off) < r_count);
        end
    end

    assign head    = r_mem[r_rd_ptr];
    assign entries = r_mem;
    assign count   = r_count;

endmodule

// File: rtl/breg_wb_queue.sv
// Write-back request buffer in front of breg's write port.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready              : request handshake from execute
//   in_y, in_wa, in_wval, in_mask  : request payload
//   hold                           : suppress the drain this cycle
//   w, y, wa, wval, mask           : breg write port, driven from the queue head
//   qa, q_busy                     : hazard query; q_busy when a queued entry writes qa
//   count                          : occupancy
// DEPTH must be a power of two, at least 2.
module breg_wb_queue
    import breg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_y,
    input  logic [3:0]                  in_wa,
    input  logic [BREG_W-1:0]           in_wval,
    input  logic [BREG_W-1:0]           in_mask,
    input  logic                        hold,
    output logic                        w,
    output logic                        y,
    output logic [3:0]                  wa,
    output logic [BREG_W-1:0]           wval,
    output logic [BREG_W-1:0]           mask,
    input  logic [3:0]                  qa,
    output logic                        q_busy,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int CW = $clog2(DEPTH+1);

    wb_req_t              w_din;
    wb_req_t              w_head;
    wb_req_t [DEPTH-1:0]  w_entries;
    logic [DEPTH-1:0]     w_valid;
    logic [CW-1:0]        w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_payload_unused;

    assign w_din = '{y: in_y, wa: in_wa, wval: in_wval, mask: in_mask};

    assign w_full  = (w_count == CW'(DEPTH));
    assign w_empty = (w_count == CW'(0));

    // No full pass-through: a same-cycle pop does not open a slot.
    assign in_ready = !w_full && !rst;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty && !hold;

    sfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_din),
        .head    (w_head),
        .count   (w_count),
        .entries (w_entries),
        .valid   (w_valid)
    );

    assign w     = w_pop;
    assign y     = w_head.y;
    assign wa    = w_head.wa;
    assign wval  = w_head.wval;
    assign mask  = w_head.mask;
    assign count = w_count;

    // Hazard flag: the entry draining this cycle still counts, since breg
    // only takes the new value at the clock edge.
    always_comb begin
        q_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && breg_hits(w_entries[i].wa, qa)) begin
                q_busy = 1'b1;
            end else begin
                q_busy = q_busy;
            end
        end
    end

    // Payload fields of the raw entry view are not needed for the hazard check.
    always_comb begin
        w_payload_unused = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_payload_unused = w_payload_unused ^ w_entries[i].y
                             ^ (^w_entries[i].wval) ^ (^w_entries[i].mask);
        end
    end

endmodule
